uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
// - Downstream of the UART TX buffer. Takes each one-cycle tx_Start strobe and its tx_Data byte.
// - Serializes the byte onto the UART line: start bit, DATA_WIDTH data bits LSB-first, optional parity, stop bit(s).
// - Reports busy, frame-done and dropped-request status back to the buffer/control logic.
// PARAMETERS
// - CLKS_PER_BIT  16  sample_Clk cycles per bit period (>=2)
// - DATA_WIDTH    8   data bits per frame (5..8)
// - PARITY_EN     0   1 = append a parity bit after the data
// - PARITY_ODD    0   0 = even parity, 1 = odd parity (used only when PARITY_EN=1)
// - STOP_BITS     1   number of stop bits (1 or 2)
// PORTS
// - sample_Clk   in   1           system/sample clock
// - reset        in   1           asynchronous, active-low reset
// - tx_Start     in   1           one-cycle request; tx_Data valid only in this cycle
// - tx_Data      in   DATA_WIDTH  byte to send
// - tx_Serial    out  1           UART line, idles high
// - tx_Busy      out  1           high from the cycle after acceptance until the frame ends
// - tx_Done      out  1           one-cycle pulse when the frame completes
// - tx_Overrun   out  1           one-cycle pulse when tx_Start arrives while busy
// BEHAVIOUR
// - Reset (async, immediate):
//   - tx_Serial=1, tx_Busy=0, tx_Done=0, tx_Overrun=0.
//   - State IDLE; counters and shift register cleared.
//   - A reset mid-frame aborts the frame; the line returns high at once.
// - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
// - IDLE:
//   - tx_Start=1 at a rising edge latches tx_Data into the shift register and computes parity from the latched byte.
//   - State goes to START. From the next cycle, tx_Busy=1 and tx_Serial=0.
// - Bit timing:
//   - A baud counter runs 0..CLKS_PER_BIT-1. Each bit is held for exactly CLKS_PER_BIT cycles.
//   - The state/bit advance happens on the cycle where the counter equals CLKS_PER_BIT-1. The counter then wraps to 0.
// - DATA:
//   - tx_Serial = shreg[0]. The register shifts right once per bit.
//   - A bit counter runs 0..DATA_WIDTH-1. After the last bit, go to PARITY if PARITY_EN, else STOP.
// - PARITY: tx_Serial = ^data ^ PARITY_ODD, held for one bit period.
// - STOP:
//   - tx_Serial=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - At the end: state IDLE, tx_Busy=0 and tx_Done=1 for one cycle, all on the same edge.
// - Latency:
//   - Start bit appears 1 cycle after the accepting edge.
//   - Frame length = (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
// - Back-to-back: tx_Start in the tx_Done cycle (state already IDLE) is accepted. The stop-bit length is unchanged and there is no idle gap.
// - Overrun:
//   - tx_Start while tx_Busy=1 sets tx_Overrun=1 for the next cycle.
//   - The request is discarded; the current frame is unaffected.
// - tx_Data is ignored in every cycle where tx_Start=0, including its non-byte idle value.
// - tx_Serial is driven from a flop (glitch-free).
// STRUCTURE
// - Shared constants in uart_Define.v: FSM state encodings (3-bit), default CLKS_PER_BIT, line idle level.
// - Sub-module uart_baud_tick:
//   - Modulo-CLKS_PER_BIT counter with clear and enable; outputs bit_Tick at count CLKS_PER_BIT-1.
//   - Cleared on frame acceptance.
// - Top level holds the FSM, bit counter, shift register, parity flop and status pulses.
// TESTING (CLKS_PER_BIT=16, DATA_WIDTH=8 unless noted)
// - Reset release, no stimulus -> tx_Serial=1, tx_Busy=0 held for 500 cycles.
// - tx_Start with 0x55 -> line reads 0,1,0,1,0,1,0,1,0,1 at bit centres; tx_Done pulses 160 cycles after the first low cycle.
// - PARITY_EN=1, even parity, send 0x11 then 0x13 -> parity bit 0, then 1. PARITY_ODD=1 inverts both.
// - Two requests, the second exactly in the tx_Done cycle (0xA5, 0x3C) -> frames contiguous; stop bit is exactly 16 cycles; two tx_Done pulses.
// - tx_Start mid-frame of 0xF0 -> tx_Overrun pulses once; 0xF0 frame intact; no extra frame follows.
// - reset asserted at data bit 3 -> tx_Serial=1 and tx_Busy=0 immediately; a new tx_Start after release sends a clean full frame.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit serializer: FSM state encoding,
// default bit timing and the line idle level.
package uart_tx_serializer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam int   DEFAULT_CLKS_PER_BIT = 16;
   localparam logic LINE_IDLE            = 1'b1;

   function automatic int count_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_tick.sv
// Modulo-CLKS_PER_BIT bit-period counter with synchronous clear and enable;
// bit_Tick marks the last cycle of each bit period.
module uart_tx_serializer_baud_tick
   import uart_tx_serializer_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int CW           = count_width(CLKS_PER_BIT)
) (
   input  logic          sample_Clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          enable,
   output logic          bit_Tick,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge sample_Clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bit_Tick = enable && (count_q == LAST);
   assign count    = count_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity and
// stop bit(s), with busy, frame-done and overrun status pulses.
module uart_tx_serializer
   import uart_tx_serializer_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_WIDTH   = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  sample_Clk,
   input  logic                  reset,
   input  logic                  tx_Start,
   input  logic [DATA_WIDTH-1:0] tx_Data,
   output logic                  tx_Serial,
   output logic                  tx_Busy,
   output logic                  tx_Done,
   output logic                  tx_Overrun
);

   localparam int CW = count_width(CLKS_PER_BIT);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic                  parity_q, parity_d;
   logic                  serial_q, serial_d;
   logic                  done_q, done_d;
   logic                  overrun_q, overrun_d;

   logic                  baud_clear;
   logic                  bit_tick;
   logic [CW-1:0]         baud_count;

   assign baud_clear = (state_q == ST_IDLE);

   uart_tx_serializer_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CW           (CW)
   ) u_baud (
      .sample_Clk (sample_Clk),
      .reset      (reset),
      .clear      (baud_clear),
      .enable     (!baud_clear),
      .bit_Tick   (bit_tick),
      .count      (baud_count)
   );

   // The last stop period ends one cycle early: the tx_Done cycle itself is the
   // final stop cycle, so a request taken then follows with no idle gap.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      done_d    = 1'b0;
      overrun_d = tx_Start && (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (tx_Start) begin
               shreg_d   = tx_Data;
               parity_d  = (^tx_Data) ^ 1'(PARITY_ODD);
               bit_cnt_d = '0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (bit_tick) begin
               bit_cnt_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               if (bit_cnt_q == 4'(DATA_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  shreg_d   = shreg_q >> 1;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_tick) begin
               bit_cnt_d = '0;
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            if ((bit_cnt_q == 4'(STOP_BITS - 1)) &&
                (baud_count == CW'(CLKS_PER_BIT - 2))) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (bit_tick) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      case (state_d)
         ST_START:  serial_d = 1'b0;
         ST_DATA:   serial_d = shreg_d[0];
         ST_PARITY: serial_d = parity_d;
         default:   serial_d = LINE_IDLE;
      endcase
   end

   always_ff @(posedge sample_Clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         serial_q  <= LINE_IDLE;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
         serial_q  <= serial_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   assign tx_Serial  = serial_q;
   assign tx_Busy    = (state_q != ST_IDLE);
   assign tx_Done    = done_q;
   assign tx_Overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: three configurations driven with
// directed and random requests, compared against a frame-level line model.
module tb_uart_tx_serializer;

   localparam int ND = 3;
   localparam int CPB_A [ND] = '{16, 16, 4};
   localparam int DW_A  [ND] = '{8, 8, 7};
   localparam int PE_A  [ND] = '{0, 1, 1};
   localparam int PO_A  [ND] = '{0, 0, 1};
   localparam int SB_A  [ND] = '{1, 1, 2};

   logic       sample_Clk = 1'b0;
   logic       reset      = 1'b0;
   logic       tx_start [ND];
   logic [7:0] data_in  [ND];
   logic       ser      [ND];
   logic       busy     [ND];
   logic       done     [ND];
   logic       ovr      [ND];

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          f0       [ND];
   int          flen     [ND];
   logic [15:0] fbits    [ND];
   int          ovr_cyc  [ND];
   int          done_seen[ND];
   int          ovr_seen [ND];

   always #5 sample_Clk = ~sample_Clk;

   uart_tx_serializer #(.CLKS_PER_BIT(16), .DATA_WIDTH(8), .PARITY_EN(0),
                        .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
      .sample_Clk(sample_Clk), .reset(reset), .tx_Start(tx_start[0]),
      .tx_Data(data_in[0]), .tx_Serial(ser[0]), .tx_Busy(busy[0]),
      .tx_Done(done[0]), .tx_Overrun(ovr[0]));

   uart_tx_serializer #(.CLKS_PER_BIT(16), .DATA_WIDTH(8), .PARITY_EN(1),
                        .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
      .sample_Clk(sample_Clk), .reset(reset), .tx_Start(tx_start[1]),
      .tx_Data(data_in[1]), .tx_Serial(ser[1]), .tx_Busy(busy[1]),
      .tx_Done(done[1]), .tx_Overrun(ovr[1]));

   uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_WIDTH(7), .PARITY_EN(1),
                        .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
      .sample_Clk(sample_Clk), .reset(reset), .tx_Start(tx_start[2]),
      .tx_Data(data_in[2][6:0]), .tx_Serial(ser[2]), .tx_Busy(busy[2]),
      .tx_Done(done[2]), .tx_Overrun(ovr[2]));

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // A frame is a bit vector: start 0, data LSB-first, parity, then stop ones.
   function automatic void buildFrame(input int d, input logic [7:0] v);
      logic [15:0] b;
      int nb;
      int ones;
      b    = '1;
      b[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < DW_A[d]; i++) begin
         b[1+i] = v[i];
         ones += int'(v[i]);
      end
      nb = 1 + DW_A[d];
      if (PE_A[d] != 0) begin
         b[nb] = 1'((ones % 2) ^ PO_A[d]);
         nb++;
      end
      nb += SB_A[d];
      fbits[d] = b;
      flen[d]  = nb * CPB_A[d];
   endfunction

   function automatic bit inFrame(input int d, input int c);
      return (c >= f0[d]) && (c < f0[d] + flen[d]);
   endfunction

   function automatic logic expSer(input int d, input int c);
      if (inFrame(d, c)) return fbits[d][(c - f0[d]) / CPB_A[d]];
      return 1'b1;
   endfunction

   function automatic logic expBusy(input int d, input int c);
      return inFrame(d, c) && ((c - f0[d]) < flen[d] - 1);
   endfunction

   function automatic logic expDone(input int d, input int c);
      return inFrame(d, c) && ((c - f0[d]) == flen[d] - 1);
   endfunction

   function automatic bit anyBusy();
      for (int d = 0; d < ND; d++) if (expBusy(d, cyc)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void clearModel();
      for (int d = 0; d < ND; d++) begin
         f0[d]      = -100000;
         flen[d]    = 0;
         fbits[d]   = '1;
         ovr_cyc[d] = -100000;
      end
   endfunction

   task automatic checkAll();
      for (int d = 0; d < ND; d++) begin
         checkOutput($sformatf("d%0d_serial", d), 32'(ser[d]), 32'(expSer(d, cyc)));
         checkOutput($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(expBusy(d, cyc)));
         checkOutput($sformatf("d%0d_done", d), 32'(done[d]), 32'(expDone(d, cyc)));
         checkOutput($sformatf("d%0d_overrun", d), 32'(ovr[d]), 32'(cyc == ovr_cyc[d]));
         if (done[d] === 1'b1) done_seen[d]++;
         if (ovr[d] === 1'b1) ovr_seen[d]++;
      end
   endtask

   // Drives a request for the next edge; the model decides accept vs overrun.
   task automatic applyStimulus(input int d, input logic [7:0] v);
      tx_start[d] = 1'b1;
      data_in[d]  = v;
      if (!expBusy(d, cyc)) begin
         f0[d] = cyc + 1;
         buildFrame(d, v);
      end else begin
         ovr_cyc[d] = cyc + 1;
      end
   endtask

   task automatic tick();
      @(posedge sample_Clk);
      cyc++;
      @(negedge sample_Clk);
      checkAll();
      for (int d = 0; d < ND; d++) begin
         tx_start[d] = 1'b0;
         data_in[d]  = 8'($urandom);
      end
   endtask

   task automatic runUntilIdle(input int max_cycles);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (anyBusy() && (n < max_cycles));
      checkOutput("idle_within_budget", {29'd0, busy[2], busy[1], busy[0]}, 32'd0);
   endtask

   initial begin
      int d0_done, d0_ovr;
      clearModel();
      for (int d = 0; d < ND; d++) begin
         tx_start[d]  = 1'b0;
         data_in[d]   = 8'hFF;
         done_seen[d] = 0;
         ovr_seen[d]  = 0;
      end

      repeat (4) tick();
      reset = 1'b1;
      repeat (500) tick();

      for (int d = 0; d < ND; d++) applyStimulus(d, 8'h55);
      runUntilIdle(400);
      repeat (3) tick();

      for (int d = 0; d < ND; d++) applyStimulus(d, 8'h11);
      runUntilIdle(400);
      for (int d = 0; d < ND; d++) applyStimulus(d, 8'h13);
      runUntilIdle(400);
      repeat (3) tick();

      d0_done = done_seen[0];
      applyStimulus(0, 8'hA5);
      for (int n = 0; n < 400 && !expDone(0, cyc); n++) tick();
      checkOutput("b2b_reached_done", 32'(done[0]), 32'd1);
      applyStimulus(0, 8'h3C);
      runUntilIdle(400);
      checkOutput("b2b_done_pulses", 32'(done_seen[0] - d0_done), 32'd2);
      repeat (3) tick();

      d0_done = done_seen[0];
      d0_ovr  = ovr_seen[0];
      applyStimulus(0, 8'hF0);
      repeat (40) tick();
      applyStimulus(0, 8'h77);
      runUntilIdle(400);
      repeat (30) tick();
      checkOutput("overrun_pulses", 32'(ovr_seen[0] - d0_ovr), 32'd1);
      checkOutput("overrun_single_frame", 32'(done_seen[0] - d0_done), 32'd1);

      applyStimulus(0, 8'h0F);
      applyStimulus(1, 8'hC3);
      repeat (72) tick();
      reset = 1'b0;
      #1;
      clearModel();
      checkAll();
      repeat (3) tick();
      reset = 1'b1;
      repeat (5) tick();
      applyStimulus(0, 8'h5A);
      runUntilIdle(400);

      for (int n = 0; n < 3000; n++) begin
         tick();
         for (int d = 0; d < ND; d++) begin
            if (expDone(d, cyc) && ($urandom_range(1, 0) == 1)) applyStimulus(d, 8'($urandom));
            else if ($urandom_range(39, 0) == 0) applyStimulus(d, 8'($urandom));
         end
      end
      runUntilIdle(400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
